tl_ram_responder: RTL
=====================

# tl_ram_responder

TileLink-UL manager endpoint that sits downstream of the A-channel client arbiter: accepts single-beat Get/PutFullData/PutPartialData requests, services them from a local flop-based 64-bit RAM, and returns AccessAck/AccessAckData on the D channel tagged with the request's source. A 2-entry response queue decouples A acceptance from D backpressure. Errors are reported with `denied`/`corrupt` per TL-UL rules, never by dropping a request.

## Interface
- DEPTH, 64: RAM words (64-bit each), power of two, 2..1024
- BASE, 32'h8000_0000: byte base address, aligned to DEPTH*8

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all control state immediately
- io_a_ready  out  1  request accepted when high with io_a_valid
- io_a_valid  in  1  request valid
- io_a_bits_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get; others unsupported
- io_a_bits_param  in  3  ignored
- io_a_bits_size  in  4  log2 bytes
- io_a_bits_source  in  2  requester tag, echoed
- io_a_bits_address  in  32  byte address
- io_a_bits_mask  in  8  byte lanes for Put
- io_a_bits_data  in  64  write data
- io_a_bits_corrupt  in  1  write data poisoned
- io_d_ready  in  1  response consumer ready
- io_d_valid  out  1  response valid
- io_d_bits_opcode  out  3  0 AccessAck, 1 AccessAckData, 2 HintAck
- io_d_bits_param  out  2  always 0
- io_d_bits_size  out  4  echo of request size
- io_d_bits_source  out  2  echo of request source
- io_d_bits_denied  out  1  request failed
- io_d_bits_data  out  64  read data (0 when not AccessAckData or denied)
- io_d_bits_corrupt  out  1  equals denied on AccessAckData, else 0

## Operation
- Response queue: 2 entries, count 0..2. io_a_ready = (count != 2); no combinational path from io_d_ready to io_a_ready.
- A fire (valid & ready): decode, perform RAM access, enqueue response at same edge. D fire dequeues head. Simultaneous enqueue+dequeue keeps count.
- io_d_valid = (count != 0); io_d_bits_* = head entry, stable while valid && !ready.
- Error checks, in order; any hit => denied=1, RAM untouched:
  - unsupported opcode (2,3 -> AccessAckData; 5 -> HintAck; 6,7 -> AccessAck)
  - size > 3
  - misaligned: address[2:0] & ((1<<size)-1) != 0
  - out of range: address - BASE >= DEPTH*8 (unsigned 32-bit)
  - Put with a_corrupt=1
- Word index = (address - BASE) >> 3, low log2(DEPTH) bits.
- Get: data = full 64-bit word (mask ignored), opcode AccessAckData. Denied Get: data 0, corrupt 1.
- Put: write lanes where mask bit set; mask 0 is a legal no-op write; opcode AccessAck.
- Get following a Put to same word, accepted next cycle, returns new data.

## Timing
- Reset values: io_d_valid 0, all io_d_bits_* 0, count 0, io_a_ready 1 after reset release. RAM contents not reset (undefined).
- Latency: request accepted at edge N -> io_d_valid high in cycle after N (1 cycle) when queue was empty.
- Throughput: 1 request/cycle sustained while io_d_ready=1.
- Full: count 2 -> io_a_ready 0 even if io_d_ready=1 that cycle; ready returns the cycle after a dequeue.
- Reset mid-operation: queued responses discarded; any Put already accepted has committed to RAM.

## Configuration
- TLRAM_STATS_EN defined: adds output io_stat_denied (16 bits), incremented on every A fire that yields denied=1, saturating at 16'hFFFF, cleared by reset.
- Not defined: port absent, no counter logic; all other behaviour identical.

## Test plan
- PutFull addr BASE+0x10, size 3, mask FF, data 0x1122334455667788, source 2 -> next cycle D: opcode 0, source 2, denied 0; then Get same addr -> opcode 1, data 0x1122334455667788, corrupt 0.
- PutPartial addr BASE+0x10, mask 0x0F, data 0xAAAA_AAAA_BBBB_BBBB -> subsequent Get returns 0x11223344BBBBBBBB.
- Hold io_d_ready=0, issue 3 Gets -> two accepted, io_a_ready 0 on third; raise io_d_ready -> responses drain in order, third accepted cycle after first dequeue.
- Get addr BASE+DEPTH*8 -> denied 1, corrupt 1, data 0; Get size 3 addr BASE+4 -> denied; opcode 5 -> HintAck, denied 1; with TLRAM_STATS_EN io_stat_denied = 3.
- Put with a_corrupt=1 to BASE+0x18 -> AccessAck denied 1; following Get returns prior word unchanged.
- Drive reset low with 2 responses queued -> io_d_valid 0 immediately, io_a_ready 1 after release.

Source files
------------

// File: rtl/tl_ram_responder.sv
// TileLink-UL RAM manager: single-beat Get/Put serviced from a flop RAM, 2-entry D response queue.
// Optional TLRAM_STATS_EN adds a saturating denied-request counter on io_stat_denied.
module tl_ram_responder #(
    parameter int          DEPTH = 64,
    parameter logic [31:0] BASE  = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_a_ready,
    input  logic        io_a_valid,
    input  logic [2:0]  io_a_bits_opcode,
    input  logic [2:0]  io_a_bits_param,
    input  logic [3:0]  io_a_bits_size,
    input  logic [1:0]  io_a_bits_source,
    input  logic [31:0] io_a_bits_address,
    input  logic [7:0]  io_a_bits_mask,
    input  logic [63:0] io_a_bits_data,
    input  logic        io_a_bits_corrupt,
    input  logic        io_d_ready,
    output logic        io_d_valid,
    output logic [2:0]  io_d_bits_opcode,
    output logic [1:0]  io_d_bits_param,
    output logic [3:0]  io_d_bits_size,
    output logic [1:0]  io_d_bits_source,
    output logic        io_d_bits_denied,
    output logic [63:0] io_d_bits_data,
    output logic        io_d_bits_corrupt
`ifdef TLRAM_STATS_EN
    ,
    output logic [15:0] io_stat_denied
`endif
);
    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN = 32'(DEPTH) * 32'd8;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [1:0]  source;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } rsp_t;

    logic [1:0]  count_q, count_d;
    rsp_t        ent0_q, ent0_d, ent1_q, ent1_d;
    logic [63:0] mem_q [DEPTH];

    logic        a_fire_s, d_fire_s, is_get_s, is_put_s, denied_s, wr_en_s;
    logic [31:0] offset_s;
    logic [AW-1:0] idx_s;
    logic [2:0]  lane_s, rop_s;
    rsp_t        new_s;
    logic        unused_s;

    assign unused_s   = ^io_a_bits_param;
    assign io_a_ready = (count_q != 2'd2);
    assign io_d_valid = (count_q != 2'd0);

    // Request decode, error classification and response construction
    always_comb begin
        a_fire_s = io_a_valid & io_a_ready;
        d_fire_s = io_d_valid & io_d_ready;
        offset_s = io_a_bits_address - BASE;
        idx_s    = offset_s[3 +: AW];
        is_get_s = (io_a_bits_opcode == 3'd4);
        is_put_s = (io_a_bits_opcode == 3'd0) || (io_a_bits_opcode == 3'd1);
        case (io_a_bits_size[1:0])
            2'd0:    lane_s = 3'b000;
            2'd1:    lane_s = 3'b001;
            2'd2:    lane_s = 3'b011;
            default: lane_s = 3'b111;
        endcase
        case (io_a_bits_opcode)
            3'd2, 3'd3, 3'd4: rop_s = 3'd1;
            3'd5:             rop_s = 3'd2;
            default:          rop_s = 3'd0;
        endcase
        denied_s = !(is_get_s || is_put_s)
                || (io_a_bits_size > 4'd3)
                || ((io_a_bits_address[2:0] & lane_s) != 3'b000)
                || (offset_s >= SPAN)
                || (is_put_s && io_a_bits_corrupt);
        wr_en_s        = a_fire_s & is_put_s & ~denied_s;
        new_s.opcode   = rop_s;
        new_s.size     = io_a_bits_size;
        new_s.source   = io_a_bits_source;
        new_s.denied   = denied_s;
        new_s.corrupt  = (rop_s == 3'd1) & denied_s;
        if (is_get_s && !denied_s) begin
            new_s.data = mem_q[idx_s];
        end else begin
            new_s.data = 64'd0;
        end
    end

    // Byte-lane RAM write; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            for (int b = 0; b < 8; b++) begin
                if (io_a_bits_mask[b]) begin
                    mem_q[idx_s][8*b +: 8] <= io_a_bits_data[8*b +: 8];
                end
            end
        end
    end

    // Response queue next state: entry 0 is always the head, so D outputs come straight from flops
    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (count_q)
            2'd0: begin
                if (a_fire_s) begin
                    ent0_d  = new_s;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                if (a_fire_s && d_fire_s) begin
                    ent0_d = new_s;
                end else if (a_fire_s) begin
                    ent1_d  = new_s;
                    count_d = 2'd2;
                end else if (d_fire_s) begin
                    ent0_d  = '0;
                    count_d = 2'd0;
                end else begin
                    count_d = 2'd1;
                end
            end
            2'd2: begin
                if (d_fire_s) begin
                    ent0_d  = ent1_q;
                    ent1_d  = '0;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd2;
                end
            end
            default: begin
                ent0_d  = '0;
                ent1_d  = '0;
                count_d = 2'd0;
            end
        endcase
    end

    // Queue state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign io_d_bits_opcode  = ent0_q.opcode;
    assign io_d_bits_param   = 2'd0;
    assign io_d_bits_size    = ent0_q.size;
    assign io_d_bits_source  = ent0_q.source;
    assign io_d_bits_denied  = ent0_q.denied;
    assign io_d_bits_data    = ent0_q.data;
    assign io_d_bits_corrupt = ent0_q.corrupt;

`ifdef TLRAM_STATS_EN
    logic [15:0] stat_q, stat_d;

    // Saturating count of denied requests
    always_comb begin
        if (a_fire_s && denied_s && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end else begin
            stat_d = stat_q;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_q <= 16'd0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign io_stat_denied = stat_q;
`endif
endmodule
